// File: rtl/proc_datapath_if.sv
// proc_datapath_if: control word from the processor FSM into the datapath,
// plus the bus/status/debug signals coming back out of it.
interface proc_datapath_if #(
  parameter int WIDTH = 8
) ();
  // control word (FSM -> datapath)
  logic [WIDTH-1:0] data_in;
  logic             data_out;
  logic [7:0]       R_out;
  logic [7:0]       R_in;
  logic             a_in;
  logic             g_in;
  logic             g_out;
  logic             AddSub;
  logic [6:0]       math_enables;
  logic [2:0]       dbg_sel;
  // status / observation (datapath -> FSM)
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] dbg_data;
  logic [WIDTH-1:0] g_value;
  logic             zero;
  logic             carry;
  logic             bus_conflict;
  logic             alu_illegal;

  modport master (
    output data_in, data_out, R_out, R_in, a_in, g_in, g_out, AddSub, math_enables, dbg_sel,
    input  bus, dbg_data, g_value, zero, carry, bus_conflict, alu_illegal
  );

  modport slave (
    input  data_in, data_out, R_out, R_in, a_in, g_in, g_out, AddSub, math_enables, dbg_sel,
    output bus, dbg_data, g_value, zero, carry, bus_conflict, alu_illegal
  );
endinterface

// File: rtl/proc_datapath.sv
// proc_datapath: register file, A/G registers, shared bus and ALU driven one
// control word per clock by the processor FSM.
// Optional feature: DATAPATH_DIVMOD_EN builds the combinational divider for
// the div/mod ops; without it a div/mod G load is flagged as illegal.

// One register-file entry.
module proc_datapath_reg_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  // entry storage, cleared by reset, loaded from the bus on write enable
  always_ff @(posedge clk) begin
    if (reset)     q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module proc_datapath #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input  logic            clk,
  input  logic            reset,
  proc_datapath_if.slave  dp_io
);
  logic [NREGS-1:0][WIDTH-1:0] r_q;
  logic [WIDTH-1:0] a_q, g_q;
  logic             zero_q, carry_q, conflict_q, illegal_q;

  logic [WIDTH-1:0] bus_d, rsel_d;
  logic [1:0]       src_cnt_d;
  logic             rout_multi_d, conflict_d;

  logic [WIDTH:0]   sum_d, diff_d;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_cy_d, alu_bad_d, g_load_d;

  // Register file: a cell that is both source and destination keeps its value.
  for (genvar g = 0; g < NREGS; g++) begin : g_rf
    proc_datapath_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .reset (reset),
      .we_i  (dp_io.R_in[g] & ~dp_io.R_out[g]),
      .d_i   (bus_d),
      .q_o   (r_q[g])
    );
  end

  // Bus source mux: data_in > G > register file (lowest set R_out bit) > 0.
  always_comb begin
    rsel_d = '0;
    for (int i = NREGS - 1; i >= 0; i--)
      if (dp_io.R_out[i]) rsel_d = r_q[i];
    if (dp_io.data_out)   bus_d = dp_io.data_in;
    else if (dp_io.g_out) bus_d = g_q;
    else                  bus_d = rsel_d;
  end

  // Protocol check: more than one bus driver class, or a multi-hot R_out.
  always_comb begin
    src_cnt_d    = {1'b0, dp_io.data_out} + {1'b0, dp_io.g_out} + {1'b0, |dp_io.R_out};
    rout_multi_d = (dp_io.R_out & (dp_io.R_out - 8'd1)) != 8'd0;
    conflict_d   = (src_cnt_d > 2'd1) | rout_multi_d;
  end

  // ALU: A op bus. Extra top bit of sum/diff gives carry-out / borrow.
  always_comb begin
    sum_d     = {1'b0, a_q} + {1'b0, bus_d};
    diff_d    = {1'b0, a_q} - {1'b0, bus_d};
    alu_res_d = '0;
    alu_cy_d  = 1'b0;
    alu_bad_d = 1'b0;
    case (dp_io.math_enables)
      7'b000_0000: begin
        if (dp_io.AddSub) begin alu_res_d = diff_d[WIDTH-1:0]; alu_cy_d = diff_d[WIDTH]; end
        else              begin alu_res_d = sum_d[WIDTH-1:0];  alu_cy_d = sum_d[WIDTH];  end
      end
      7'b100_0000: alu_res_d = a_q ^ bus_d;
      7'b010_0000: begin alu_res_d = sum_d[WIDTH-1:0];  alu_cy_d = sum_d[WIDTH];  end
      7'b001_0000: begin alu_res_d = diff_d[WIDTH-1:0]; alu_cy_d = diff_d[WIDTH]; end
      7'b000_1000: alu_res_d = a_q & bus_d;
      7'b000_0100: alu_res_d = a_q | bus_d;
`ifdef DATAPATH_DIVMOD_EN
      // divide by zero: quotient saturates to all ones, remainder is A
      7'b000_0010: alu_res_d = (bus_d == '0) ? '1  : a_q / bus_d;
      7'b000_0001: alu_res_d = (bus_d == '0) ? a_q : a_q % bus_d;
`else
      7'b000_0010: alu_bad_d = 1'b1;
      7'b000_0001: alu_bad_d = 1'b1;
`endif
      default:     alu_bad_d = 1'b1;
    endcase
  end

  // G only loads when it is not also driving the bus (writeback step holds G).
  assign g_load_d = dp_io.g_in & ~dp_io.g_out;

  // A, G, status flags and one-cycle violation pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      g_q        <= '0;
      zero_q     <= 1'b1;
      carry_q    <= 1'b0;
      conflict_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (dp_io.a_in) a_q <= bus_d;
      conflict_q <= conflict_d;
      illegal_q  <= g_load_d & alu_bad_d;
      if (g_load_d && !alu_bad_d) begin
        g_q     <= alu_res_d;
        zero_q  <= (alu_res_d == '0);
        carry_q <= alu_cy_d;
      end
    end
  end

  assign dp_io.bus          = bus_d;
  assign dp_io.dbg_data     = r_q[dp_io.dbg_sel];
  assign dp_io.g_value      = g_q;
  assign dp_io.zero         = zero_q;
  assign dp_io.carry        = carry_q;
  assign dp_io.bus_conflict = conflict_q;
  assign dp_io.alu_illegal  = illegal_q;
endmodule

// File: tb/tb_proc_datapath.sv
// tb_proc_datapath: directed spot checks plus randomized control words,
// compared every cycle against a behavioural model of the datapath.
module tb_proc_datapath;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  proc_datapath_if #(.WIDTH(8)) dif ();

  proc_datapath #(.WIDTH(8), .NREGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .dp_io (dif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  logic [7:0] m_r [8];
  logic [7:0] m_a, m_g;
  logic       m_zero, m_carry, m_conf, m_ill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_bus();
    if (dif.data_out) return dif.data_in;
    if (dif.g_out)    return m_g;
    for (int i = 0; i < 8; i++)
      if (dif.R_out[i]) return m_r[i];
    return 8'h00;
  endfunction

  // Advance the model by one clock edge using the pre-edge inputs.
  task automatic model_step();
    int a, b, res, srcs;
    bit cy, bad;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
      m_a = 0; m_g = 0; m_zero = 1; m_carry = 0; m_conf = 0; m_ill = 0;
      return;
    end
    b    = int'(m_bus());
    a    = int'(m_a);
    srcs = int'(dif.data_out) + int'(dif.g_out) + int'(dif.R_out != 0);
    m_conf = (srcs > 1) || (dif.R_out != 0 && $countones(dif.R_out) != 1);
    res = 0; cy = 0; bad = 0;
    case (dif.math_enables)
      7'h00: if (dif.AddSub) begin res = a - b; cy = (a < b); end
             else            begin res = a + b; cy = (res > 255); end
      7'h40: res = a ^ b;
      7'h20: begin res = a + b; cy = (res > 255); end
      7'h10: begin res = a - b; cy = (a < b); end
      7'h08: res = a & b;
      7'h04: res = a | b;
`ifdef DATAPATH_DIVMOD_EN
      7'h02: res = (b == 0) ? 255 : a / b;
      7'h01: res = (b == 0) ? a : a % b;
`endif
      default: bad = 1;
    endcase
    res = res & 255;
    m_ill = dif.g_in && !dif.g_out && bad;
    if (dif.g_in && !dif.g_out && !bad) begin
      m_g = res[7:0]; m_zero = (res == 0); m_carry = cy;
    end
    for (int i = 0; i < 8; i++)
      if (dif.R_in[i] && !dif.R_out[i]) m_r[i] = b[7:0];
    if (dif.a_in) m_a = b[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear();
    dif.data_in = 0; dif.data_out = 0; dif.R_out = 0; dif.R_in = 0;
    dif.a_in = 0; dif.g_in = 0; dif.g_out = 0; dif.AddSub = 0; dif.math_enables = 0;
  endtask

  task automatic ld(input int idx, input logic [7:0] val);
    clear(); dif.data_out = 1; dif.data_in = val; dif.R_in = 8'h01 << idx;
    tick(); clear();
  endtask

  task automatic rd(input string name, input int idx, input logic [7:0] exp);
    dif.dbg_sel = idx[2:0];
    #1;
    check(name, dif.dbg_data, exp);
  endtask

  // G load from the bus driven by data_in, A unchanged.
  task automatic gload(input logic [7:0] v, input logic [6:0] op);
    clear(); dif.data_out = 1; dif.data_in = v; dif.g_in = 1; dif.math_enables = op;
    tick(); clear();
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bus",          dif.bus,          m_bus());
      check("dbg_data",     dif.dbg_data,     m_r[dif.dbg_sel]);
      check("g_value",      dif.g_value,      m_g);
      check("zero",         dif.zero,         m_zero);
      check("carry",        dif.carry,        m_carry);
      check("bus_conflict", dif.bus_conflict, m_conf);
      check("alu_illegal",  dif.alu_illegal,  m_ill);
    end
  end

  initial begin
    clear(); dif.dbg_sel = 0; reset = 1;
    tick(); chk_en = 1; tick();
    reset = 0;

    // reset state
    check("rst_zero", dif.zero, 1); check("rst_g", dif.g_value, 0);
    check("rst_carry", dif.carry, 0); check("rst_conf", dif.bus_conflict, 0);
    check("rst_ill", dif.alu_illegal, 0);
    rd("rst_r5", 5, 8'h00);

    // load
    ld(2, 8'h5A); rd("load_r2", 2, 8'h5A);

    // add with carry: R1 = F0 + 20
    ld(1, 8'hF0); ld(2, 8'h20);
    dif.R_out = 8'h02; dif.a_in = 1; tick(); clear();
    dif.R_out = 8'h04; dif.a_in = 1; dif.g_in = 1; dif.math_enables = 7'h20; tick(); clear();
    check("add_g", dif.g_value, 8'h10); check("add_carry", dif.carry, 1); check("add_zero", dif.zero, 0);
    dif.g_out = 1; dif.g_in = 1; dif.R_in = 8'h02; tick(); clear();
    rd("add_r1", 1, 8'h10); check("wb_carry_hold", dif.carry, 1);

    // sub to zero
    ld(3, 8'h33); ld(4, 8'h33);
    dif.R_out = 8'h08; dif.a_in = 1; tick(); clear();
    dif.R_out = 8'h10; dif.a_in = 1; dif.g_in = 1; dif.math_enables = 7'h10; tick(); clear();
    dif.g_out = 1; dif.g_in = 1; dif.R_in = 8'h08; tick(); clear();
    rd("sub_r3", 3, 8'h00); rd("sub_r4", 4, 8'h33);
    check("sub_zero", dif.zero, 1); check("sub_carry", dif.carry, 0);

    // AddSub path with borrow: A=33, bus=40
    dif.data_out = 1; dif.data_in = 8'h40; dif.g_in = 1; dif.AddSub = 1; tick(); clear();
    check("addsub_g", dif.g_value, 8'hF3); check("addsub_borrow", dif.carry, 1);

    // div/mod with A = 17
    dif.data_out = 1; dif.data_in = 8'h17; dif.a_in = 1; tick(); clear();
    gload(8'h05, 7'h02);
`ifdef DATAPATH_DIVMOD_EN
    check("div_g", dif.g_value, 8'h04); check("div_ill", dif.alu_illegal, 0);
    gload(8'h05, 7'h01); check("mod_g", dif.g_value, 8'h03);
    gload(8'h00, 7'h02); check("div0_g", dif.g_value, 8'hFF);
    gload(8'h00, 7'h01); check("mod0_g", dif.g_value, 8'h17);
`else
    check("div_hold_g", dif.g_value, 8'hF3); check("div_ill", dif.alu_illegal, 1);
    tick(); check("div_ill_clr", dif.alu_illegal, 0);
    gload(8'h05, 7'h01); check("mod_hold_g", dif.g_value, 8'hF3); check("mod_ill", dif.alu_illegal, 1);
`endif
    // multi-hot op is illegal, G holds
    begin
      logic [7:0] g_before;
      g_before = m_g;
      gload(8'h01, 7'h60);
      check("multi_ill", dif.alu_illegal, 1); check("multi_hold_g", dif.g_value, g_before);
      tick(); check("multi_ill_clr", dif.alu_illegal, 0);
    end

    // bus conflicts
    dif.data_out = 1; dif.data_in = 8'hC3; dif.R_out = 8'h01; #1;
    check("conf_bus", dif.bus, 8'hC3);
    tick(); clear(); check("conf_pulse", dif.bus_conflict, 1);
    tick(); check("conf_clr", dif.bus_conflict, 0);
    dif.R_out = 8'h06; #1; check("rout_low_bus", dif.bus, 8'h10);
    tick(); clear(); check("rout_multi_conf", dif.bus_conflict, 1);

    // reset between op step and writeback
    ld(1, 8'hF0); ld(2, 8'h20);
    dif.R_out = 8'h02; dif.a_in = 1; tick(); clear();
    dif.R_out = 8'h04; dif.a_in = 1; dif.g_in = 1; dif.math_enables = 7'h20; tick(); clear();
    reset = 1; tick(); reset = 0;
    check("mrst_zero", dif.zero, 1); check("mrst_g", dif.g_value, 0); rd("mrst_r2", 2, 8'h00);
    dif.g_out = 1; dif.g_in = 1; dif.R_in = 8'h02; tick(); clear();
    rd("mrst_wb_r1", 1, 8'h00); check("mrst_wb_zero", dif.zero, 1);

    // randomized control words
    for (int c = 0; c < 3000; c++) begin
      dif.data_in  = 8'($urandom);
      dif.data_out = ($urandom_range(0, 3) == 0);
      dif.g_out    = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0, 1:    dif.R_out = 8'h00;
        2, 3, 4: dif.R_out = 8'h01 << $urandom_range(0, 7);
        default: dif.R_out = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1:    dif.R_in = 8'h01 << $urandom_range(0, 7);
        2:       dif.R_in = 8'($urandom);
        default: dif.R_in = 8'h00;
      endcase
      dif.a_in   = 1'($urandom);
      dif.g_in   = 1'($urandom);
      dif.AddSub = 1'($urandom);
      case ($urandom_range(0, 6))
        0:       dif.math_enables = 7'h00;
        6:       dif.math_enables = 7'($urandom);
        default: dif.math_enables = 7'h01 << $urandom_range(0, 6);
      endcase
      dif.dbg_sel = 3'($urandom);
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 0; clear(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
